// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types and constants for the ALU sequencer
package alu_seq_pkg;

    localparam int OP_W     = 3;
    localparam int DEF_DW   = 8;
    localparam int DEF_NREG = 4;

    // Explicit encodings keep the state values stable for anything that
    // inspects the raw state bits.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_e;

endpackage

// File: rtl/alu_seq_regfile.sv
// rtl/alu_seq_regfile.sv - NREG x DW register file, 1 sync write, 3 comb reads
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high clear
//   we, waddr, wdata  synchronous write port
//   ra_addr/ra_data   combinational read port A
//   rb_addr/rb_data   combinational read port B
//   dbg_addr/dbg_data combinational debug read port
module alu_seq_regfile
    import alu_seq_pkg::*;
#(
    parameter int   DW   = DEF_DW,
    parameter int   NREG = DEF_NREG,
    localparam int  RAW  = $clog2(NREG)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           we,
    input  logic [RAW-1:0] waddr,
    input  logic [DW-1:0]  wdata,
    input  logic [RAW-1:0] ra_addr,
    output logic [DW-1:0]  ra_data,
    input  logic [RAW-1:0] rb_addr,
    output logic [DW-1:0]  rb_data,
    input  logic [RAW-1:0] dbg_addr,
    output logic [DW-1:0]  dbg_data
);

    logic [DW-1:0] mem [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign ra_data  = mem[ra_addr];
    assign rb_data  = mem[rb_addr];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - read/execute/writeback sequencer around an external combinational ALU
//
// Optional feature macro: ALU_SEQ_ZFLAG_EN (adds zero-flag output zf).
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_op/rd/ra/rb/use_imm/imm/use_cf  command fields
//   alu_op/a/b/ci                 registered operands to the ALU
//   alu_result/alu_co             ALU outputs, captured at writeback
//   wb_valid/wb_rd/wb_data        one-cycle writeback report
//   cf                            carry flag
//   zf                            zero flag (only with ALU_SEQ_ZFLAG_EN)
//   dbg_addr/dbg_data             combinational register peek
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int   DW   = DEF_DW,
    parameter int   NREG = DEF_NREG,
    localparam int  RAW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [OP_W-1:0] cmd_op,
    input  logic [RAW-1:0]  cmd_rd,
    input  logic [RAW-1:0]  cmd_ra,
    input  logic [RAW-1:0]  cmd_rb,
    input  logic            cmd_use_imm,
    input  logic [DW-1:0]   cmd_imm,
    input  logic            cmd_use_cf,
    output logic [OP_W-1:0] alu_op,
    output logic [DW-1:0]   alu_a,
    output logic [DW-1:0]   alu_b,
    output logic            alu_ci,
    input  logic [DW-1:0]   alu_result,
    input  logic            alu_co,
    output logic            wb_valid,
    output logic [RAW-1:0]  wb_rd,
    output logic [DW-1:0]   wb_data,
    output logic            cf,
`ifdef ALU_SEQ_ZFLAG_EN
    output logic            zf,
`endif
    input  logic [RAW-1:0]  dbg_addr,
    output logic [DW-1:0]   dbg_data
);

    state_e         state;
    logic [RAW-1:0] rd_q;
    logic [DW-1:0]  ra_data;
    logic [DW-1:0]  rb_data;
    logic           accept;
    logic           rf_we;

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    // The ALU output is stable during EXEC because alu_* only move on accept.
    assign rf_we     = (state == EXEC);

    alu_seq_regfile #(
        .DW   (DW),
        .NREG (NREG)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (rf_we),
        .waddr    (rd_q),
        .wdata    (alu_result),
        .ra_addr  (cmd_ra),
        .ra_data  (ra_data),
        .rb_addr  (cmd_rb),
        .rb_data  (rb_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            alu_op   <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_ci   <= 1'b0;
            rd_q     <= '0;
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            cf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        // Operands come from the register file as it stands
                        // now; the previous writeback has already landed.
                        alu_op <= cmd_op;
                        alu_a  <= ra_data;
                        alu_b  <= cmd_use_imm ? cmd_imm : rb_data;
                        alu_ci <= cmd_use_cf & cf;
                        rd_q   <= cmd_rd;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    wb_valid <= 1'b1;
                    wb_rd    <= rd_q;
                    wb_data  <= alu_result;
                    cf       <= alu_co;
                    state    <= WB;
                end
                WB: begin
                    wb_valid <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    wb_valid <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_ZFLAG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            zf <= 1'b0;
        end else if (state == EXEC) begin
            zf <= (alu_result == '0);
        end
    end
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - directed self-checking bench for alu_seq_ctrl
module tb_alu_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [1:0] cmd_rd;
    logic [1:0] cmd_ra;
    logic [1:0] cmd_rb;
    logic       cmd_use_imm;
    logic [7:0] cmd_imm;
    logic       cmd_use_cf;
    logic [2:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_ci;
    logic [7:0] alu_result;
    logic       alu_co;
    logic       wb_valid;
    logic [1:0] wb_rd;
    logic [7:0] wb_data;
    logic       cf;
`ifdef ALU_SEQ_ZFLAG_EN
    logic       zf;
`endif
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.DW(8), .NREG(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_rd      (cmd_rd),
        .cmd_ra      (cmd_ra),
        .cmd_rb      (cmd_rb),
        .cmd_use_imm (cmd_use_imm),
        .cmd_imm     (cmd_imm),
        .cmd_use_cf  (cmd_use_cf),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ci      (alu_ci),
        .alu_result  (alu_result),
        .alu_co      (alu_co),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .cf          (cf),
`ifdef ALU_SEQ_ZFLAG_EN
        .zf          (zf),
`endif
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // Drives a command at a negedge while IDLE, lets it be accepted, then
    // scrambles the command inputs; returns at the negedge inside EXEC.
    task automatic accept_cmd(input logic [2:0] op, input logic [1:0] rd,
                              input logic [1:0] ra, input logic [1:0] rb,
                              input logic use_imm, input logic [7:0] imm,
                              input logic use_cf);
        cmd_op      = op;
        cmd_rd      = rd;
        cmd_ra      = ra;
        cmd_rb      = rb;
        cmd_use_imm = use_imm;
        cmd_imm     = imm;
        cmd_use_cf  = use_cf;
        cmd_valid   = 1'b1;
        @(negedge clk);
        cmd_valid   = 1'b0;
        cmd_op      = ~op;
        cmd_ra      = ~ra;
        cmd_rb      = ~rb;
        cmd_imm     = 8'hEE;
        cmd_use_imm = ~use_imm;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b want 1", cmd_ready); end
        n_cmp++; if (cf !== 1'b0) begin n_err++; $display("FAIL rst_cf got %b want 0", cf); end
        n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL rst_wb_valid got %b want 0", wb_valid); end
        n_cmp++; if (alu_a !== 8'h00 || alu_op !== 3'd0) begin n_err++; $display("FAIL rst_alu got a=%h op=%0d want 0", alu_a, alu_op); end
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            n_cmp++; if (dbg_data !== 8'h00) begin n_err++; $display("FAIL rst_reg%0d got %h want 00", i, dbg_data); end
        end
        rst = 1'b0;
        @(negedge clk);
        // Reset asserted while a command sits in EXEC drops it.
        accept_cmd(3'd1, 2'd1, 2'd0, 2'd0, 1'b1, 8'h09, 1'b0);
        rst        = 1'b1;
        alu_result = 8'h77;
        alu_co     = 1'b1;
        @(negedge clk);
        n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL midrst_wb_valid got %b want 0", wb_valid); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready got %b want 1", cmd_ready); end
        n_cmp++; if (cf !== 1'b0) begin n_err++; $display("FAIL midrst_cf got %b want 0", cf); end
        dbg_addr = 2'd1;
        #1;
        n_cmp++; if (dbg_data !== 8'h00) begin n_err++; $display("FAIL midrst_reg1 got %h want 00", dbg_data); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_immediate;
        accept_cmd(3'd3, 2'd1, 2'd0, 2'd0, 1'b1, 8'h04, 1'b0);
        n_cmp++; if (alu_op !== 3'd3) begin n_err++; $display("FAIL imm_op got %0d want 3", alu_op); end
        n_cmp++; if (alu_a !== 8'h00) begin n_err++; $display("FAIL imm_a got %h want 00", alu_a); end
        n_cmp++; if (alu_b !== 8'h04) begin n_err++; $display("FAIL imm_b got %h want 04", alu_b); end
        n_cmp++; if (alu_ci !== 1'b0) begin n_err++; $display("FAIL imm_ci got %b want 0", alu_ci); end
        n_cmp++; if (cmd_ready !== 1'b0 || wb_valid !== 1'b0) begin n_err++; $display("FAIL imm_exec got ready=%b wbv=%b want 0/0", cmd_ready, wb_valid); end
        alu_result = 8'h2A;
        alu_co     = 1'b1;
        @(negedge clk);
        dbg_addr = 2'd1;
        #1;
        n_cmp++; if (wb_valid !== 1'b1) begin n_err++; $display("FAIL imm_wb_valid got %b want 1", wb_valid); end
        n_cmp++; if (wb_rd !== 2'd1 || wb_data !== 8'h2A) begin n_err++; $display("FAIL imm_wb got rd=%0d data=%h want 1/2a", wb_rd, wb_data); end
        n_cmp++; if (cf !== 1'b1) begin n_err++; $display("FAIL imm_cf got %b want 1", cf); end
        n_cmp++; if (dbg_data !== 8'h2A) begin n_err++; $display("FAIL imm_reg1 got %h want 2a", dbg_data); end
        n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL imm_wb_ready got %b want 0", cmd_ready); end
        @(negedge clk);
        n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL imm_wb_drop got %b want 0", wb_valid); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL imm_idle_ready got %b want 1", cmd_ready); end
        n_cmp++; if (alu_op !== 3'd3 || alu_b !== 8'h04) begin n_err++; $display("FAIL imm_hold got op=%0d b=%h want 3/04", alu_op, alu_b); end
    endtask

    task automatic test_carry_chain;
        accept_cmd(3'd5, 2'd3, 2'd1, 2'd1, 1'b0, 8'h00, 1'b1);
        n_cmp++; if (alu_a !== 8'h2A || alu_b !== 8'h2A) begin n_err++; $display("FAIL cc_ab got a=%h b=%h want 2a/2a", alu_a, alu_b); end
        n_cmp++; if (alu_ci !== 1'b1) begin n_err++; $display("FAIL cc_ci got %b want 1", alu_ci); end
        alu_result = 8'h55;
        alu_co     = 1'b0;
        @(negedge clk);
        n_cmp++; if (cf !== 1'b0) begin n_err++; $display("FAIL cc_cf got %b want 0", cf); end
        n_cmp++; if (wb_rd !== 2'd3 || wb_data !== 8'h55) begin n_err++; $display("FAIL cc_wb got rd=%0d data=%h want 3/55", wb_rd, wb_data); end
        @(negedge clk);
        // With cf now clear, use_cf must feed a zero carry-in.
        accept_cmd(3'd6, 2'd0, 2'd3, 2'd1, 1'b0, 8'h00, 1'b1);
        n_cmp++; if (alu_a !== 8'h55 || alu_b !== 8'h2A || alu_ci !== 1'b0) begin n_err++; $display("FAIL cc2 got a=%h b=%h ci=%b want 55/2a/0", alu_a, alu_b, alu_ci); end
        alu_result = 8'h80;
        alu_co     = 1'b0;
        repeat (2) @(negedge clk);
        dbg_addr = 2'd0;
        #1;
        n_cmp++; if (dbg_data !== 8'h80) begin n_err++; $display("FAIL cc2_reg0 got %h want 80", dbg_data); end
    endtask

    task automatic test_self_overwrite;
        accept_cmd(3'd0, 2'd2, 2'd0, 2'd0, 1'b1, 8'h05, 1'b0);
        alu_result = 8'h05;
        alu_co     = 1'b0;
        repeat (2) @(negedge clk);
        accept_cmd(3'd7, 2'd2, 2'd2, 2'd2, 1'b0, 8'h00, 1'b0);
        n_cmp++; if (alu_a !== 8'h05 || alu_b !== 8'h05) begin n_err++; $display("FAIL self_ab got a=%h b=%h want 05/05", alu_a, alu_b); end
        alu_result = 8'hFF;
        alu_co     = 1'b1;
        @(negedge clk);
        dbg_addr = 2'd2;
        #1;
        n_cmp++; if (dbg_data !== 8'hFF) begin n_err++; $display("FAIL self_reg2 got %h want ff", dbg_data); end
        n_cmp++; if (cf !== 1'b1) begin n_err++; $display("FAIL self_cf got %b want 1", cf); end
`ifdef ALU_SEQ_ZFLAG_EN
        n_cmp++; if (zf !== 1'b0) begin n_err++; $display("FAIL self_zf got %b want 0", zf); end
`endif
        @(negedge clk);
    endtask

`ifdef ALU_SEQ_ZFLAG_EN
    task automatic test_zflag;
        accept_cmd(3'd1, 2'd2, 2'd2, 2'd2, 1'b0, 8'h00, 1'b0);
        alu_result = 8'h00;
        alu_co     = 1'b0;
        @(negedge clk);
        n_cmp++; if (zf !== 1'b1) begin n_err++; $display("FAIL zf_set got %b want 1", zf); end
        @(negedge clk);
        n_cmp++; if (zf !== 1'b1) begin n_err++; $display("FAIL zf_hold got %b want 1", zf); end
        accept_cmd(3'd1, 2'd2, 2'd2, 2'd2, 1'b0, 8'h00, 1'b0);
        alu_result = 8'h01;
        @(negedge clk);
        n_cmp++; if (zf !== 1'b0) begin n_err++; $display("FAIL zf_clr got %b want 0", zf); end
        @(negedge clk);
    endtask
`endif

    task automatic test_back_to_back;
        int acc = 0;
        int wbs = 0;
        cmd_op      = 3'd2;
        cmd_rd      = 2'd3;
        cmd_ra      = 2'd0;
        cmd_rb      = 2'd0;
        cmd_use_imm = 1'b1;
        cmd_imm     = 8'h10;
        cmd_use_cf  = 1'b0;
        alu_result  = 8'h10;
        alu_co      = 1'b0;
        cmd_valid   = 1'b1;
        for (int i = 0; i < 12; i++) begin
            n_cmp++; if (cmd_ready !== (i % 3 == 0)) begin n_err++; $display("FAIL b2b_ready[%0d] got %b want %b", i, cmd_ready, (i % 3 == 0)); end
            if (cmd_ready) acc++;
            @(negedge clk);
            if (wb_valid) wbs++;
        end
        cmd_valid = 1'b0;
        n_cmp++; if (acc !== 4) begin n_err++; $display("FAIL b2b_accepts got %0d want 4", acc); end
        n_cmp++; if (wbs !== 4) begin n_err++; $display("FAIL b2b_wb_pulses got %0d want 4", wbs); end
        dbg_addr = 2'd3;
        #1;
        n_cmp++; if (dbg_data !== 8'h10) begin n_err++; $display("FAIL b2b_reg3 got %h want 10", dbg_data); end
        @(negedge clk);
    endtask

    initial begin
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = '0;
        cmd_rd      = '0;
        cmd_ra      = '0;
        cmd_rb      = '0;
        cmd_use_imm = 1'b0;
        cmd_imm     = '0;
        cmd_use_cf  = 1'b0;
        alu_result  = '0;
        alu_co      = 1'b0;
        dbg_addr    = '0;
        @(negedge clk);
        test_reset();
        test_immediate();
        test_carry_chain();
        test_self_overwrite();
`ifdef ALU_SEQ_ZFLAG_EN
        test_zflag();
`endif
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Sequencing stage that sits directly upstream of the 8-bit combinational ALU and also consumes its output. It accepts one command at a time over a valid/ready handshake and reads operands from a small register file. It drives the ALU's op/A/B/ci inputs from registers, then captures result/co into the destination register and a carry flag. Each command therefore runs a full read–execute–writeback cycle against the ALU.

Parameters:
DW, 8, datapath width; must equal the ALU's A/B/result width.
NREG, 4, register-file depth; power of two, at least 2.
RAW, $clog2(NREG), register address width (derived, not overridable).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command
cmd_op  input  3  ALU opcode, passed through unmodified
cmd_rd  input  RAW  destination register
cmd_ra  input  RAW  source A register
cmd_rb  input  RAW  source B register
cmd_use_imm  input  1  1: B operand = cmd_imm; 0: B operand = reg[cmd_rb]
cmd_imm  input  DW  immediate operand
cmd_use_cf  input  1  1: ci = carry flag; 0: ci = 0
alu_op  output  3  to ALU op
alu_a  output  DW  to ALU A
alu_b  output  DW  to ALU B
alu_ci  output  1  to ALU ci
alu_result  input  DW  from ALU result
alu_co  input  1  from ALU co
wb_valid  output  1  one-cycle pulse on writeback
wb_rd  output  RAW  register written
wb_data  output  DW  value written
cf  output  1  carry flag
dbg_addr  input  RAW  debug read address
dbg_data  output  DW  reg[dbg_addr], combinational

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst sampled on the rising edge). No asynchronous paths.
- Reset values:
  - state = IDLE, cmd_ready = 1.
  - alu_op, alu_a, alu_b, alu_ci = 0.
  - wb_valid = 0, wb_rd = 0, wb_data = 0.
  - cf = 0, all registers = 0.
- FSM states: IDLE, EXEC, WB.
  - IDLE: cmd_ready = 1. On cmd_valid & cmd_ready:
    - register alu_op = cmd_op.
    - alu_a = reg[cmd_ra].
    - alu_b = cmd_use_imm ? cmd_imm : reg[cmd_rb].
    - alu_ci = cmd_use_cf & cf.
    - latch cmd_rd.
    - go to EXEC.
  - EXEC: cmd_ready = 0. ALU outputs settle combinationally. At the clock edge, capture alu_result/alu_co into reg[rd]/cf, set wb_valid = 1 with wb_rd/wb_data, go to WB.
  - WB: cmd_ready = 0. wb_valid deasserts. alu_* outputs hold their last values. Go to IDLE.
- Throughput and latency:
  - One command per 3 cycles.
  - Accept edge at T; wb_valid high during cycle T+2 (between edges T+1 and T+2).
  - New reg[rd] visible on dbg_data from T+2.
- alu_* outputs are registered and change only on an accept edge.
- Operand reads use register values as of the accept edge. A command whose ra/rb equals the previous rd reads the written-back value; no hazard exists, because acceptance is impossible before WB completes.
- ra == rb == rd is legal: the old value is read and the new value is written.
- Widths: alu_result is stored as-is with no extension or truncation. cf is updated on every writeback, regardless of cmd_use_cf.
- rst asserted in any state returns to IDLE on that edge. Any in-flight command is dropped: no writeback, and registers/cf are cleared.
- cmd_valid while cmd_ready = 0 is ignored. Command inputs need not be held stable after acceptance.

Optional Feature:
ALU_SEQ_ZFLAG_EN
- Defined:
  - adds output port zf (1 bit), reset 0.
  - at each writeback, zf = (alu_result == 0); holds otherwise.
- Undefined: port zf does not exist and no zero-detect logic is built.

Decomposition:
- Package alu_seq_pkg holds:
  - state enum (IDLE/EXEC/WB).
  - localparam OP_W = 3.
  - default DW/NREG constants.
- One sub-module is natural: alu_seq_regfile. It has NREG×DW entries, one synchronous write port, and two combinational read ports plus the debug read port; its reset clears all entries.

Test Plan:
- The bench models the ALU by driving alu_result/alu_co directly, so the checks are independent of op encoding.
- Reset: hold rst 2 cycles -> cmd_ready=1, cf=0, wb_valid=0, dbg_data=0 for all addresses; assert rst mid-EXEC -> no wb_valid, state IDLE next cycle.
- Immediate path: cmd {op=3, rd=1, ra=0, use_imm=1, imm=8'h04}, bench returns result=8'h2A, co=1 -> at T+1 alu_op=3, alu_a=0, alu_b=4, alu_ci=0; wb_valid once at T+2 with wb_rd=1, wb_data=8'h2A; cf=1; dbg_data[1]=8'h2A.
- Carry chaining: with cf=1, cmd {use_cf=1, ra=1, rb=1, use_imm=0} -> alu_a=alu_b=8'h2A, alu_ci=1; returned co=0 clears cf.
- Back-pressure: cmd_valid held high continuously -> exactly one accept every 3 cycles; cmd_ready low in EXEC/WB; 4 commands yield 4 wb pulses in 12 cycles.
- Self-overwrite: rd=ra=rb=2 with reg2=8'h05, bench returns 8'hFF -> alu_a=alu_b=5, reg2=8'hFF afterward; with ALU_SEQ_ZFLAG_EN, a returned result of 8'h00 sets zf=1 and a following 8'h01 clears it.
